sreg_universal: RTL

//  Parametrised multi-mode shift/rotate register. Successor to the fixed 8-bit, 1-position rotator.

---
 rtl/sreg_universal_if.sv | 28 ++
 rtl/sreg_universal.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sreg_universal_if.sv
// Bus bundle for sreg_universal: parallel load, run request and status taps.
// The master side drives the run request; the slave side is the shift register itself.
interface sreg_universal_if #(
   parameter int N  = 8,
   parameter int AW = 4
);
   logic          load;
   logic [N-1:0]  D;
   logic          start;
   logic [2:0]    op;
   logic [AW-1:0] amt;
   logic          sin;
   logic          busy;
   logic          done;
   logic [N-1:0]  Q;
   logic          sout_r;
   logic          sout_l;

   modport master (
      output load, D, start, op, amt, sin,
      input  busy, done, Q, sout_r, sout_l
   );

   modport slave (
      input  load, D, start, op, amt, sin,
      output busy, done, Q, sout_r, sout_l
   );
endinterface

// File: rtl/sreg_universal.sv
// Multi-mode shift/rotate register: parallel load, then a sequenced run of 'amt'
// positions moving up to STEP positions per clock, with a busy/done handshake.
module sreg_universal #(
   parameter int N    = 8,
   parameter int STEP = 1,
   parameter int AW   = 4
) (
   input logic          sys_clk,
   input logic          sys_rst_n,
   sreg_universal_if.slave bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;
   typedef enum logic [2:0] {
      OP_ROR = 3'b000, OP_ROL = 3'b001, OP_SRL = 3'b010, OP_SLL = 3'b011,
      OP_SRA = 3'b100, OP_SRI = 3'b101, OP_SLI = 3'b110, OP_RSV = 3'b111
   } op_e;

   // A single step never exceeds what rem can hold, so cap STEP to keep step_amt in AW bits.
   localparam int            STEP_CAP = (STEP < (2**AW - 1)) ? STEP : (2**AW - 1);
   localparam logic [AW-1:0] STEP_V   = AW'(STEP_CAP);

   state_e              state_reg, state_next;
   op_e                 op_reg, op_next;
   logic [N-1:0]        q_reg, q_next;
   logic [AW-1:0]       rem_reg, rem_next;
   logic                done_reg, done_next;
   logic [AW-1:0]       step_amt;
   logic [N-1:0]        q_shift;
   logic [STEP_CAP:0][N-1:0] cand;

   assign step_amt = (rem_reg > STEP_V) ? STEP_V : rem_reg;
   assign cand[0]  = q_reg;

   // One candidate result per possible step size; the run picks the one matching min(STEP, rem).
   genvar gi;
   generate
      for (gi = 1; gi <= STEP_CAP; gi++) begin : g_step
         logic [2*N-1:0]      rot_r, rot_l, ins_r, ins_l;
         logic [N-1:0]        fill;
         logic signed [N-1:0] sra_val;
         logic [N-1:0]        res;

         assign fill    = {N{bus.sin}};
         assign rot_r   = {q_reg, q_reg} >> gi;
         assign rot_l   = {q_reg, q_reg} << gi;
         assign ins_r   = {fill, q_reg} >> gi;
         assign ins_l   = {q_reg, fill} << gi;
         assign sra_val = $signed(q_reg) >>> gi;

         always_comb begin
            res = q_reg;
            case (op_reg)
               OP_ROR:  res = rot_r[N-1:0];
               OP_ROL:  res = rot_l[2*N-1:N];
               OP_SRL:  res = q_reg >> gi;
               OP_SLL:  res = q_reg << gi;
               OP_SRA:  res = sra_val;
               OP_SRI:  res = ins_r[N-1:0];
               OP_SLI:  res = ins_l[2*N-1:N];
               default: res = q_reg;
            endcase
         end

         assign cand[gi] = res;
      end
   endgenerate

   always_comb begin
      q_shift = q_reg;
      for (int k = 0; k <= STEP_CAP; k++) begin
         if (step_amt == AW'(k)) begin
            q_shift = cand[k];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      q_next     = q_reg;
      rem_next   = rem_reg;
      done_next  = 1'b0;

      if (bus.load) begin
         // Load takes priority over everything and silently aborts any run in flight.
         q_next     = bus.D;
         state_next = IDLE;
         rem_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start && (bus.op != OP_RSV)) begin
                  if (bus.amt == '0) begin
                     done_next = 1'b1;
                  end else begin
                     op_next    = op_e'(bus.op);
                     rem_next   = bus.amt;
                     state_next = RUN;
                  end
               end
            end
            RUN: begin
               q_next   = q_shift;
               rem_next = rem_reg - step_amt;
               if (rem_reg == step_amt) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= IDLE;
         op_reg    <= OP_ROR;
         q_reg     <= '0;
         rem_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         q_reg     <= q_next;
         rem_reg   <= rem_next;
         done_reg  <= done_next;
      end
   end

   assign bus.Q      = q_reg;
   assign bus.busy   = (state_reg == RUN);
   assign bus.done   = done_reg;
   assign bus.sout_r = q_reg[0];
   assign bus.sout_l = q_reg[N-1];
endmodule
